exe_mem_pipe_reg: RTL and testbench
===================================

Name: exe_mem_pipe_reg

Overview:
Parametrised, elastic EXE->MEM pipeline register for the RISC-V core. It replaces the free-running EXE/MEM latch with a valid/ready handshake, a 2-entry skid buffer, synchronous flush and bubble insertion. With it, MEM-stage back-pressure (cache miss, multi-cycle store) stalls EXE without a combinational ready path. It sits between the ALU/branch unit and the data-memory interface.

Parameters:
XLEN, 64, width of ALU result, store data and branch target
REG_ADDR_W, 5, width of destination register index
MEM_TYPE_W, 2, width of memory access size/type field

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
valid_e  in  1  EXE presents a valid instruction
ready_e  out  1  register can accept (registered, no comb path from ready_m)
flush  in  1  synchronous kill of all held entries (branch redirect/trap)
reg_write_e, mem_write_e, mem_to_reg_e, mem_read_e  in  1 each  control bits
mem_type_e  in  MEM_TYPE_W  access size/type
pc_src_e  in  1  branch taken
alu_result_e  in  XLEN  ALU result / address
write_data_e  in  XLEN  store data
rd_e  in  REG_ADDR_W  destination register
pc_target_e  in  XLEN  branch target
valid_m  out  1  output entry valid
ready_m  in  1  MEM stage accepts
reg_write_m, mem_write_m, mem_to_reg_m, mem_read_m, mem_type_m, pc_src_m, alu_result_m, write_data_m, rd_m, pc_target_m  out  same widths  registered copies

Behaviour:
- Transfer in: valid_e && ready_e at posedge. Transfer out: valid_m && ready_m at posedge.
- Storage: main entry (drives *_m) plus skid entry. States: EMPTY (no valid entry), ONE (main valid), TWO (main+skid valid).
- ready_e = !skid_valid, registered; high in EMPTY and ONE, low in TWO.
- EMPTY: in -> main loaded, ONE. Else stay.
- ONE: in & out -> main reloaded, ONE. in & !out -> input to skid, TWO. !in & out -> EMPTY. Neither -> hold.
- TWO: out -> skid moves to main, ONE (no input accepted this cycle, ready_e low). !out -> hold all.
- Latency: 1 cycle valid_e -> valid_m when EMPTY or ONE with ready_m high. Full throughput: one instruction per cycle with ready_m held high.
- Order preserved; no entry is dropped or duplicated.
- Bubble rule: when valid_m=0, reg_write_m, mem_write_m, mem_read_m, mem_to_reg_m, pc_src_m are forced 0. Data fields hold their last value.
- flush (sync, highest priority): next state EMPTY. Main and skid valid cleared, control bits zeroed. The input offered that cycle is discarded. ready_e is 1 the cycle after.
- Reset (async, reset_n low, any time including mid-stall): state EMPTY, valid_m=0, ready_e=1. All *_m outputs are 0, including data fields and mem_type_m.
- Reset release is synchronous to clk by the integrating design. There is no first-cycle special case.
- X on data inputs while valid_e=0 must not propagate to *_m control outputs.

Optional Feature:
Macro EXE_MEM_PERF_EN.
- Defined: adds output port stall_cnt [31:0]. It increments every cycle valid_m && !ready_m and saturates at 32'hFFFF_FFFF. It clears on reset only; flush does not clear it.
- Undefined: port and counter absent. Behaviour otherwise identical.

Test Plan:
- Reset mid-stream: drive 3 valid items, assert reset_n=0 in TWO -> valid_m=0, ready_e=1, all *_m=0 asynchronously; after release, first accepted item appears next cycle.
- Streaming: ready_m=1, valid_e=1 with rd_e=1..8, alu_result_e=64'h10..64'h80 -> rd_m 1..8 on consecutive cycles, 1-cycle latency, ready_e constant 1.
- Back-pressure: ready_m=0 after items A(rd=3), B(rd=4) accepted -> ready_e=0, valid_m=1, rd_m=3 held. Then ready_m=1 -> rd_m=4 next cycle, ready_e=1 the cycle after skid drains.
- Flush in TWO with valid_e=1 (rd=7) -> next cycle valid_m=0, reg_write_m=0, mem_write_m=0. Item 7 never appears.
- Bubble: valid_e=0 with reg_write_e=1, mem_write_e=1 -> reg_write_m=0, mem_write_m=0, valid_m=0.
- EXE_MEM_PERF_EN: hold valid_m=1, ready_m=0 for 10 cycles -> stall_cnt=10. Flush -> stall_cnt stays 10. Reset -> 0.

Source files
------------

// File: rtl/exe_mem_pipe_reg.sv
// rtl/exe_mem_pipe_reg.sv - elastic EXE->MEM pipeline register with 2-entry skid buffer
// Optional stall counter port stall_cnt is enabled by defining EXE_MEM_PERF_EN.
module exe_mem_pipe_reg #(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5,
  parameter int MEM_TYPE_W = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  valid_e,
  output logic                  ready_e,
  input  logic                  flush,
  input  logic                  reg_write_e,
  input  logic                  mem_write_e,
  input  logic                  mem_to_reg_e,
  input  logic                  mem_read_e,
  input  logic [MEM_TYPE_W-1:0] mem_type_e,
  input  logic                  pc_src_e,
  input  logic [XLEN-1:0]       alu_result_e,
  input  logic [XLEN-1:0]       write_data_e,
  input  logic [REG_ADDR_W-1:0] rd_e,
  input  logic [XLEN-1:0]       pc_target_e,
  output logic                  valid_m,
  input  logic                  ready_m,
  output logic                  reg_write_m,
  output logic                  mem_write_m,
  output logic                  mem_to_reg_m,
  output logic                  mem_read_m,
  output logic [MEM_TYPE_W-1:0] mem_type_m,
  output logic                  pc_src_m,
  output logic [XLEN-1:0]       alu_result_m,
  output logic [XLEN-1:0]       write_data_m,
  output logic [REG_ADDR_W-1:0] rd_m,
  output logic [XLEN-1:0]       pc_target_m
`ifdef EXE_MEM_PERF_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic                  regWrite;
    logic                  memWrite;
    logic                  memToReg;
    logic                  memRead;
    logic                  pcSrc;
    logic [MEM_TYPE_W-1:0] memType;
    logic [XLEN-1:0]       aluResult;
    logic [XLEN-1:0]       writeData;
    logic [XLEN-1:0]       pcTarget;
    logic [REG_ADDR_W-1:0] rd;
  } entry_t;

  state_t state, stateNext;
  entry_t mainEntry, mainNext;
  entry_t skidEntry, skidNext;
  entry_t inEntry;
  logic   readyReg, readyNext;
  logic   inXfer, outXfer;

  // Flushed entries keep their data but must never look like live instructions.
  function automatic entry_t killCtrl(input entry_t e);
    entry_t r;
    r          = e;
    r.regWrite = 1'b0;
    r.memWrite = 1'b0;
    r.memToReg = 1'b0;
    r.memRead  = 1'b0;
    r.pcSrc    = 1'b0;
    return r;
  endfunction

  always_comb begin
    inEntry           = '0;
    inEntry.regWrite  = reg_write_e;
    inEntry.memWrite  = mem_write_e;
    inEntry.memToReg  = mem_to_reg_e;
    inEntry.memRead   = mem_read_e;
    inEntry.pcSrc     = pc_src_e;
    inEntry.memType   = mem_type_e;
    inEntry.aluResult = alu_result_e;
    inEntry.writeData = write_data_e;
    inEntry.pcTarget  = pc_target_e;
    inEntry.rd        = rd_e;
  end

  assign inXfer  = valid_e && readyReg;
  assign outXfer = (state != EMPTY) && ready_m;

  always_comb begin
    stateNext = state;
    mainNext  = mainEntry;
    skidNext  = skidEntry;
    if (flush) begin
      stateNext = EMPTY;
      mainNext  = killCtrl(mainEntry);
      skidNext  = killCtrl(skidEntry);
    end else begin
      case (state)
        EMPTY: begin
          if (inXfer) begin
            mainNext  = inEntry;
            stateNext = ONE;
          end
        end
        ONE: begin
          if (inXfer && outXfer) begin
            mainNext = inEntry;
          end else if (inXfer) begin
            skidNext  = inEntry;
            stateNext = TWO;
          end else if (outXfer) begin
            stateNext = EMPTY;
          end
        end
        TWO: begin
          // readyReg is low here, so nothing can enter while the skid drains.
          if (outXfer) begin
            mainNext  = skidEntry;
            stateNext = ONE;
          end
        end
        default: stateNext = EMPTY;
      endcase
    end
    readyNext = (stateNext != TWO);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= EMPTY;
      mainEntry <= '0;
      skidEntry <= '0;
      readyReg  <= 1'b1;
    end else begin
      state     <= stateNext;
      mainEntry <= mainNext;
      skidEntry <= skidNext;
      readyReg  <= readyNext;
    end
  end

  assign ready_e      = readyReg;
  assign valid_m      = (state != EMPTY);
  assign reg_write_m  = mainEntry.regWrite && valid_m;
  assign mem_write_m  = mainEntry.memWrite && valid_m;
  assign mem_to_reg_m = mainEntry.memToReg && valid_m;
  assign mem_read_m   = mainEntry.memRead  && valid_m;
  assign pc_src_m     = mainEntry.pcSrc    && valid_m;
  assign mem_type_m   = mainEntry.memType;
  assign alu_result_m = mainEntry.aluResult;
  assign write_data_m = mainEntry.writeData;
  assign rd_m         = mainEntry.rd;
  assign pc_target_m  = mainEntry.pcTarget;

`ifdef EXE_MEM_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (valid_m && !ready_m && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_exe_mem_pipe_reg.sv
// tb/tb_exe_mem_pipe_reg.sv - scoreboard bench for exe_mem_pipe_reg
module tb_exe_mem_pipe_reg;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] alu;
    logic [63:0] wd;
    logic [63:0] pct;
    logic [6:0]  ctrl;
  } item_t;

  logic        clk = 1'b0;
  logic        reset_n, valid_e, ready_e, flush;
  logic        reg_write_e, mem_write_e, mem_to_reg_e, mem_read_e, pc_src_e;
  logic [1:0]  mem_type_e;
  logic [63:0] alu_result_e, write_data_e, pc_target_e;
  logic [4:0]  rd_e;
  logic        valid_m, ready_m;
  logic        reg_write_m, mem_write_m, mem_to_reg_m, mem_read_m, pc_src_m;
  logic [1:0]  mem_type_m;
  logic [63:0] alu_result_m, write_data_m, pc_target_m;
  logic [4:0]  rd_m;
`ifdef EXE_MEM_PERF_EN
  logic [31:0] stall_cnt;
`endif

  int    total = 0;
  int    bad   = 0;
  item_t sb[$];

  always #5 clk = ~clk;

  exe_mem_pipe_reg dut (
    .clk(clk), .reset_n(reset_n), .valid_e(valid_e), .ready_e(ready_e), .flush(flush),
    .reg_write_e(reg_write_e), .mem_write_e(mem_write_e), .mem_to_reg_e(mem_to_reg_e),
    .mem_read_e(mem_read_e), .mem_type_e(mem_type_e), .pc_src_e(pc_src_e),
    .alu_result_e(alu_result_e), .write_data_e(write_data_e), .rd_e(rd_e),
    .pc_target_e(pc_target_e), .valid_m(valid_m), .ready_m(ready_m),
    .reg_write_m(reg_write_m), .mem_write_m(mem_write_m), .mem_to_reg_m(mem_to_reg_m),
    .mem_read_m(mem_read_m), .mem_type_m(mem_type_m), .pc_src_m(pc_src_m),
    .alu_result_m(alu_result_m), .write_data_m(write_data_m), .rd_m(rd_m),
    .pc_target_m(pc_target_m)
`ifdef EXE_MEM_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Each rd selects a distinct, hand-checkable payload: alu = rd*16, control bits from rd bits.
  function automatic item_t mk(input logic [4:0] rd);
    item_t it;
    it.rd   = rd;
    it.alu  = 64'(rd) << 4;
    it.wd   = 64'hA000 + 64'(rd);
    it.pct  = 64'h8000_0000 + (64'(rd) << 2);
    it.ctrl = {rd[0], rd[1], rd[2], ~rd[0], rd[3], rd[1:0]};
    return it;
  endfunction

  task automatic drive(input logic [4:0] rd);
    item_t it;
    it = mk(rd);
    valid_e = 1'b1;
    rd_e = it.rd; alu_result_e = it.alu; write_data_e = it.wd; pc_target_e = it.pct;
    {reg_write_e, mem_write_e, mem_to_reg_e, mem_read_e, pc_src_e, mem_type_e} = it.ctrl;
  endtask

  task automatic idle();
    valid_e = 1'b0; rd_e = '0; alu_result_e = '0; write_data_e = '0; pc_target_e = '0;
    {reg_write_e, mem_write_e, mem_to_reg_e, mem_read_e, pc_src_e, mem_type_e} = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, ".valid_m"}, 64'(valid_m), 64'd0);
    chk({nm, ".ready_e"}, 64'(ready_e), 64'd1);
    chk({nm, ".rd_m"}, 64'(rd_m), 64'd0);
    chk({nm, ".alu_result_m"}, alu_result_m, 64'd0);
    chk({nm, ".write_data_m"}, write_data_m, 64'd0);
    chk({nm, ".pc_target_m"}, pc_target_m, 64'd0);
    chk({nm, ".ctrl_m"}, 64'({reg_write_m, mem_write_m, mem_to_reg_m, mem_read_m, pc_src_m, mem_type_m}), 64'd0);
  endtask

  // Issue side: record every accepted instruction; flush and reset discard everything in flight.
  always @(negedge clk) begin
    if (!reset_n || flush) sb.delete();
    else if (valid_e && ready_e) sb.push_back(mk(rd_e));
  end

  // Monitor: every output transfer must match the oldest outstanding instruction.
  always @(negedge clk) begin
    item_t ex;
    if (reset_n && valid_m && ready_m) begin
      if (sb.size() == 0) begin
        chk("mon.unexpected_rd", 64'(rd_m), 64'h1F);
      end else begin
        ex = sb.pop_front();
        chk("mon.rd", 64'(rd_m), 64'(ex.rd));
        chk("mon.alu", alu_result_m, ex.alu);
        chk("mon.wdata", write_data_m, ex.wd);
        chk("mon.target", pc_target_m, ex.pct);
        chk("mon.ctrl", 64'({reg_write_m, mem_write_m, mem_to_reg_m, mem_read_m, pc_src_m, mem_type_m}), 64'(ex.ctrl));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; flush = 1'b0; ready_m = 1'b0;
    idle();
    tick(); tick();
    chk_reset("reset");
    reset_n = 1'b1;
    tick();

    // Streaming: one per cycle, 1-cycle latency, ready_e never drops.
    ready_m = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(5'(i));
      tick();
      chk("stream.valid_m", 64'(valid_m), 64'd1);
      chk("stream.rd_m", 64'(rd_m), 64'(i));
      chk("stream.alu_m", alu_result_m, 64'(i * 16));
      chk("stream.ready_e", 64'(ready_e), 64'd1);
    end
    idle();
    tick();
    chk("stream.drain_valid", 64'(valid_m), 64'd0);

    // Back-pressure: A(3), B(4) fill both entries; C(9) waits until the skid drains.
    ready_m = 1'b0;
    drive(5'd3); tick();
    chk("bp.one_rd", 64'(rd_m), 64'd3);
    chk("bp.one_ready", 64'(ready_e), 64'd1);
    drive(5'd4); tick();
    chk("bp.two_ready", 64'(ready_e), 64'd0);
    chk("bp.two_valid", 64'(valid_m), 64'd1);
    chk("bp.two_rd", 64'(rd_m), 64'd3);
    drive(5'd9); tick();
    chk("bp.hold_rd", 64'(rd_m), 64'd3);
    chk("bp.hold_ready", 64'(ready_e), 64'd0);
    ready_m = 1'b1; tick();
    chk("bp.drain_rd", 64'(rd_m), 64'd4);
    chk("bp.drain_ready", 64'(ready_e), 64'd1);
    tick();
    chk("bp.late_rd", 64'(rd_m), 64'd9);
    idle(); tick();
    chk("bp.empty_valid", 64'(valid_m), 64'd0);

    // Flush in TWO with an instruction offered.
    ready_m = 1'b0;
    drive(5'd5); tick();
    drive(5'd6); tick();
    chk("flush2.pre_ready", 64'(ready_e), 64'd0);
    chk("flush2.pre_regwr", 64'(reg_write_m), 64'd1);
    drive(5'd7); flush = 1'b1; tick();
    flush = 1'b0; idle();
    chk("flush2.valid_m", 64'(valid_m), 64'd0);
    chk("flush2.reg_write_m", 64'(reg_write_m), 64'd0);
    chk("flush2.mem_write_m", 64'(mem_write_m), 64'd0);
    chk("flush2.ready_e", 64'(ready_e), 64'd1);
    ready_m = 1'b1; tick();
    chk("flush2.after_valid", 64'(valid_m), 64'd0);

    // Flush in ONE while the offered instruction would otherwise be accepted.
    ready_m = 1'b0;
    drive(5'd10); tick();
    chk("flush1.pre_rd", 64'(rd_m), 64'd10);
    drive(5'd11); flush = 1'b1; tick();
    flush = 1'b0; idle();
    chk("flush1.valid_m", 64'(valid_m), 64'd0);
    ready_m = 1'b1; tick();
    chk("flush1.after_valid", 64'(valid_m), 64'd0);

    // Bubble: control inputs high without valid_e must not reach the outputs.
    idle(); reg_write_e = 1'b1; mem_write_e = 1'b1; mem_read_e = 1'b1;
    tick();
    chk("bubble.valid_m", 64'(valid_m), 64'd0);
    chk("bubble.reg_write_m", 64'(reg_write_m), 64'd0);
    chk("bubble.mem_write_m", 64'(mem_write_m), 64'd0);
    chk("bubble.mem_read_m", 64'(mem_read_m), 64'd0);
    idle();

    // Asynchronous reset while both entries are full.
    ready_m = 1'b0;
    drive(5'd1); tick();
    drive(5'd2); tick();
    drive(5'd3); tick();
    chk("midrst.pre_ready", 64'(ready_e), 64'd0);
    reset_n = 1'b0;
    #1;
    chk_reset("midrst");
    tick();
    reset_n = 1'b1;
    drive(5'd12); ready_m = 1'b1;
    tick();
    chk("midrst.first_valid", 64'(valid_m), 64'd1);
    chk("midrst.first_rd", 64'(rd_m), 64'd12);
    idle(); tick();
    chk("midrst.empty_valid", 64'(valid_m), 64'd0);

`ifdef EXE_MEM_PERF_EN
    chk("perf.start", 64'(stall_cnt), 64'd0);
    ready_m = 1'b0;
    drive(5'd13); tick();
    idle();
    repeat (10) tick();
    chk("perf.ten", 64'(stall_cnt), 64'd10);
    ready_m = 1'b1; tick();
    ready_m = 1'b0; flush = 1'b1; tick();
    flush = 1'b0;
    chk("perf.after_flush", 64'(stall_cnt), 64'd10);
    reset_n = 1'b0;
    #1;
    chk("perf.reset", 64'(stall_cnt), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
`endif

    chk("scoreboard.leftover", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
